// File: rtl/cpu_pkg.sv
// Shared processor-controller definitions: datapath width and the down-counter state encoding.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dec.sv
// Combinational decrementer, the mirror of the PC incrementer.
module dec #(
    parameter int unsigned width = 32
) (
    input  logic [width-1:0] in_val,
    output logic [width-1:0] out_val
);

    assign out_val = in_val - width'(1);

endmodule

// File: rtl/loop_down_counter.sv
// Loadable down-counter with start/busy/done handshake and optional auto-reload,
// used for repeat loops, multi-cycle ALU iteration counts and bus wait states.
module loop_down_counter
    import cpu_pkg::*;
#(
    parameter int unsigned width = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             start,
    input  logic             auto,
    input  logic             hold,
    output logic [width-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    state_e             state_q, state_d;
    logic [width-1:0]   count_q, count_d;
    logic [width-1:0]   reload_q, reload_d;
    logic               auto_q, auto_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [width-1:0]   count_dec;

    dec #(.width(width)) u_dec (
        .in_val  (count_q),
        .out_val (count_dec)
    );

    // Next state and next count; clear beats load beats start.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        auto_d   = auto_q;

        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            auto_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        count_d  = load_val;
                        reload_d = load_val;
                    end else if (start) begin
                        if (count_q != '0) begin
                            state_d = ST_RUN;
                            auto_d  = auto;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    // Guarded so the count can never wrap from zero to all-ones.
                    if (!hold && count_q != '0) begin
                        count_d = count_dec;
                        if (count_q == width'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (auto_q && reload_q != '0) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end else begin
                        count_d = '0;
                        auto_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    auto_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            auto_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            auto_q   <= auto_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign zero  = (count_q == '0);

endmodule

// File: doc/loop_down_counter.md
# loop_down_counter

Loadable down-counter with start/busy/done handshake for the multi-cycle processor controller. It counts an iteration or wait value down to zero, one step per enabled cycle, and emits a single-cycle `done` pulse. An optional auto-reload restarts the count. It is the decrementing counterpart to the PC incrementer and is used for repeat loops, multi-cycle ALU iteration counts and bus wait states.

## Interface
- `width`, 32, bit width of count, load value and reload register.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `clear` input 1: synchronous abort; highest priority.
- `load` input 1: capture `load_val` into count and reload register (IDLE only).
- `load_val` input `width`: value to load.
- `start` input 1: begin counting (IDLE only).
- `auto` input 1: sampled with `start`; when set, reload and rerun after each completion.
- `hold` input 1: freeze the decrement in RUN.
- `count` output `width`: current count value, registered.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle completion pulse, registered.
- `zero` output 1: `count == 0`, combinational from the `count` register.

## Operation
- States: IDLE, RUN, DONE. Every output is registered except `zero`.
- Reset (async, `rst_n` = 0): state = IDLE; `count`, reload register and `auto_q` = 0; `busy` = 0; `done` = 0; `zero` = 1.
- Input priority each edge: `clear` > `load` > `start`.
- **IDLE**
  - `load`: `count` and `reload_q` take `load_val`; state stays IDLE.
  - `start` with `count != 0`: go to RUN and latch `auto_q` = `auto`.
  - `start` with `count == 0`: go directly to DONE.
  - `load` and `start` in the same cycle: `load` wins and `start` is ignored.
- **RUN**
  - `hold` = 0: `count` <= `count` − 1.
  - When `count == 1` and `hold` = 0: `count` becomes 0 and state goes to DONE.
  - `hold` = 1: `count` and state are unchanged.
  - `load` and `start` are ignored.
- **DONE** (lasts exactly one cycle; `done` = 1)
  - `auto_q` = 1 and `reload_q != 0`: `count` <= `reload_q`, go to RUN.
  - Otherwise: go to IDLE with `count` = 0 and `auto_q` cleared.
  - `load` and `start` are ignored.
- `clear` in any state: `count` = 0, `auto_q` = 0, state = IDLE, no `done` pulse. `reload_q` is retained.
- Arithmetic: unsigned modulo 2^`width`, but RUN never decrements from 0, so `count` never wraps to all-ones.
- `load_val` = 2^`width`−1 is legal and counts the full range.

## Timing
- Start sampled at edge k with value N ≥ 1 and no `hold`:
  - `busy` rises after edge k.
  - `count` reads N−j after edge k+j.
  - `count` = 0 and `done` = 1 in the cycle after edge k+N.
  - `busy` and `done` are never high together.
- N = 0: `done` is high in the cycle after edge k; `busy` never rises.
- Each RUN cycle with `hold` = 1 adds one cycle to the latency.
- Auto mode: between consecutive `done` pulses there are exactly `reload_q` + 1 cycles (no `hold`). RUN restarts in the cycle after DONE.
- `load` is visible on `count` the cycle after its edge. `start` may be asserted in that same next cycle.
- Reset asserted mid-RUN: outputs go to their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package/header `cpu_pkg`:
  - state encodings `ST_IDLE` = 2'd0, `ST_RUN` = 2'd1, `ST_DONE` = 2'd2;
  - default datapath width constant (32).
- One sub-module `dec`: parameterised combinational decrementer (`out = in - 1`), the mirror of the existing incrementer. It is instantiated once for the RUN path.
- Next-state/next-count logic goes in one combinational block; all registers go in a single async-reset sequential block.

## Test plan
- Reset, then load 5, start, no hold → `busy` high for 5 cycles, `count` 5,4,3,2,1,0, single `done` pulse 5 cycles after start edge, then IDLE.
- Load 0, start → `done` the next cycle, `busy` never asserted, `zero` = 1 throughout.
- Load 4, start, `hold` high for 3 cycles mid-count → `done` 7 cycles after start; `count` frozen while held.
- Load 3, start with `auto` = 1 → `done` pulses every 4 cycles; then `clear` → IDLE, `count` = 0, no further `done`; `load` asserted during RUN has no effect.
- Load 32'hFFFF_FFFF with `width` = 32 → first decrement gives 32'hFFFF_FFFE and no wrap. Separately, with `width` = 4, load 15 → exactly 15 decrements, then `done`.
- Deassert `rst_n` mid-RUN between clock edges → `count` = 0, `busy` = 0, `done` = 0 immediately; `start` after release behaves as from power-up.
